// File: rtl/clk_reset_pkg.sv
// Shared types and sizing helpers for the clock-enable / reset sequencer.
package clk_reset_pkg;

    // Sequencer phases: hold all resets, release channels one by one, then run.
    typedef enum logic [1:0] {
        HOLD,
        STAGE,
        RUN
    } seq_state_t;

    // Channel index width; wide enough for the 3-bit div_sel bus (up to 8 channels).
    localparam int IDX_W = 3;

    // Width of a counter that must reach max_count inclusive.
    // Used for the hold counter (HOLD_CYCLES) and the stage gap timer.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable clock-enable divider with a glitch-free shadowed ratio.
module clk_div_chan #(
    parameter int               DIV_W     = 8,
    parameter logic [DIV_W-1:0] RESET_DIV = 8'd2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             we,
    input  logic [DIV_W-1:0] val,
    output logic             ce,
    output logic             phase,
    output logic             wrap,
    output logic             disabled
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] d_act;
    logic [DIV_W-1:0] d_shadow;
    logic [DIV_W-1:0] cnt;
    logic             pend;
    logic [DIV_W-1:0] d_next;
    logic [DIV_W-1:0] cnt_next;
    logic             ce_next;
    logic             phase_next;

    // Next ratio/count: a new ratio only takes effect at a wrap, or at once when disabled.
    always_comb begin
        disabled = (d_act == '0);
        wrap     = !disabled && (cnt == d_act - ONE);
        d_next   = d_act;
        cnt_next = cnt;
        if (disabled) begin
            if (we) begin
                d_next   = val;
                cnt_next = '0;
            end
        end else if (wrap) begin
            cnt_next = '0;
            if (we) begin
                d_next = val;
            end else if (pend) begin
                d_next = d_shadow;
            end
        end else begin
            cnt_next = cnt + ONE;
        end
        ce_next    = (d_next != '0) && (cnt_next == d_next - ONE);
        phase_next = (d_next != '0) && (cnt_next >= (d_next >> 1));
    end

    // Divider state; frozen at reset values until the synchronised release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_act    <= RESET_DIV;
            d_shadow <= RESET_DIV;
            pend     <= 1'b0;
            cnt      <= '0;
            ce       <= 1'b0;
            phase    <= 1'b0;
        end else if (run) begin
            d_act <= d_next;
            cnt   <= cnt_next;
            ce    <= ce_next;
            phase <= phase_next;
            if (we && !disabled && !wrap) begin
                d_shadow <= val;
                pend     <= 1'b1;
            end else if (wrap || disabled) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_reset_seq.sv
// Derived clock enables plus a power-on / soft-reset sequencer that releases
// each channel's reset in order, aligned to that channel's own wrap.
module clk_reset_seq
    import clk_reset_pkg::*;
#(
    parameter int                          NUM_CHAN    = 2,
    parameter int                          DIV_W       = 8,
    parameter logic [NUM_CHAN*DIV_W-1:0]   DEFAULT_DIV = {8'd8, 8'd2},
    parameter int                          HOLD_CYCLES = 16,
    parameter int                          STAGE_GAP   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sw_rst,
    input  logic                div_we,
    input  logic [2:0]          div_sel,
    input  logic [DIV_W-1:0]    div_val,
    output logic [NUM_CHAN-1:0] ce,
    output logic [NUM_CHAN-1:0] phase,
    output logic [NUM_CHAN-1:0] rst_out_n,
    output logic                ready
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(STAGE_GAP);

    logic [1:0]          sync_ff;
    logic                run;
    logic [NUM_CHAN-1:0] wrap;
    logic [NUM_CHAN-1:0] disabled;

    seq_state_t          state, state_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic [GAP_W-1:0]    gap_cnt, gap_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [NUM_CHAN-1:0] rst_next;
    logic                ready_next;
    logic                sel_wrap;
    logic                sel_dis;

    // Two-flop release synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
        end
    end

    assign run = sync_ff[1];

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .RESET_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .run      (run),
            .we       (div_we && (div_sel == IDX_W'(g))),
            .val      (div_val),
            .ce       (ce[g]),
            .phase    (phase[g]),
            .wrap     (wrap[g]),
            .disabled (disabled[g])
        );
    end

    // Sequencer next state: sw_rst wins, otherwise hold, stage releases, then run.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        gap_next   = gap_cnt;
        idx_next   = idx;
        rst_next   = rst_out_n;
        ready_next = ready;
        sel_wrap   = 1'b0;
        sel_dis    = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_wrap = wrap[i];
                sel_dis  = disabled[i];
            end
        end
        if (gap_cnt < GAP_W'(STAGE_GAP)) begin
            gap_next = gap_cnt + GAP_W'(1);
        end
        if (sw_rst) begin
            state_next = HOLD;
            hold_next  = '0;
            gap_next   = '0;
            idx_next   = '0;
            rst_next   = '0;
            ready_next = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_next = STAGE;
                        idx_next   = '0;
                        gap_next   = '0;
                    end else begin
                        hold_next = hold_cnt + HOLD_W'(1);
                    end
                end
                STAGE: begin
                    if (((idx == '0) || (gap_cnt >= GAP_W'(STAGE_GAP))) &&
                        (sel_wrap || sel_dis)) begin
                        for (int i = 0; i < NUM_CHAN; i++) begin
                            if (idx == IDX_W'(i)) begin
                                rst_next[i] = 1'b1;
                            end
                        end
                        gap_next = GAP_W'(1);
                        if (idx == IDX_W'(NUM_CHAN - 1)) begin
                            state_next = RUN;
                            ready_next = 1'b1;
                        end else begin
                            idx_next = idx + IDX_W'(1);
                        end
                    end
                end
                RUN: begin
                    ready_next = 1'b1;
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    // Sequencer registers; idle until the synchronised release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            ready     <= 1'b0;
        end else if (run) begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            gap_cnt   <= gap_next;
            idx       <= idx_next;
            rst_out_n <= rst_next;
            ready     <= ready_next;
        end
    end

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq: power-on table, then hand-written
// sequences for ratio changes, disabled channel, soft and async reset.
module tb_clk_reset_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sw_rst;
    logic       div_we;
    logic [2:0] div_sel;
    logic [7:0] div_val;
    logic [1:0] ce;
    logic [1:0] phase;
    logic [1:0] rst_out_n;
    logic       ready;

    typedef struct {
        int         cyc;
        logic [1:0] ce;
        logic [1:0] phase;
        logic [1:0] rst;
        logic       ready;
    } vec_t;

    vec_t vecs[15];
    int   n_now;
    int   check_count;
    int   pass_count;

    clk_reset_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw_rst    (sw_rst),
        .div_we    (div_we),
        .div_sel   (div_sel),
        .div_val   (div_val),
        .ce        (ce),
        .phase     (phase),
        .rst_out_n (rst_out_n),
        .ready     (ready)
    );

    // 10 ns clock; posedges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance from a negedge to the negedge after update number 'target'.
    task automatic stepTo(input int target);
        if (target > n_now) begin
            repeat (target - n_now) @(posedge clk);
            #5;
            n_now = target;
        end
    endtask

    // Drive one cycle of inputs from a negedge; they are sampled at the next posedge.
    task automatic applyStimulus(input logic we, input logic [2:0] sel, input logic [7:0] val, input logic sw);
        div_we  = we;
        div_sel = sel;
        div_val = val;
        sw_rst  = sw;
        @(posedge clk);
        #5;
        n_now++;
        div_we  = 1'b0;
        div_sel = 3'd0;
        div_val = 8'd0;
        sw_rst  = 1'b0;
    endtask

    // Record ce[0], ce[1], phase[1] over the next 'count' cycles, bit i = i-th cycle.
    task automatic captureBits(input int count, output logic [31:0] c0, output logic [31:0] c1, output logic [31:0] p1);
        c0 = '0;
        c1 = '0;
        p1 = '0;
        for (int i = 0; i < count; i++) begin
            stepTo(n_now + 1);
            c0[i] = ce[0];
            c1[i] = ce[1];
            p1[i] = phase[1];
        end
    endtask

    initial begin
        logic [31:0] c0, c1, p1;
        logic        seen;

        check_count = 0;
        pass_count  = 0;
        n_now       = 0;
        reset_n     = 1'b0;
        sw_rst      = 1'b0;
        div_we      = 1'b0;
        div_sel     = 3'd0;
        div_val     = 8'd0;

        // cycle = update count after synchronised release (D0=2, D1=8)
        vecs[0]  = '{0,  2'b00, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1,  2'b01, 2'b01, 2'b00, 1'b0};
        vecs[2]  = '{2,  2'b00, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{3,  2'b01, 2'b01, 2'b00, 1'b0};
        vecs[4]  = '{4,  2'b00, 2'b10, 2'b00, 1'b0};
        vecs[5]  = '{7,  2'b11, 2'b11, 2'b00, 1'b0};
        vecs[6]  = '{8,  2'b00, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{15, 2'b11, 2'b11, 2'b00, 1'b0};
        vecs[8]  = '{16, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[9]  = '{17, 2'b01, 2'b01, 2'b00, 1'b0};
        vecs[10] = '{18, 2'b00, 2'b00, 2'b01, 1'b0};
        vecs[11] = '{21, 2'b01, 2'b11, 2'b01, 1'b0};
        vecs[12] = '{23, 2'b11, 2'b11, 2'b01, 1'b0};
        vecs[13] = '{24, 2'b00, 2'b00, 2'b11, 1'b1};
        vecs[14] = '{25, 2'b01, 2'b01, 2'b11, 1'b1};

        #50;
        checkOutput("in_reset", {25'd0, ce, phase, rst_out_n, ready}, 32'd0);
        #50;
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        n_now = 0;

        // Power-on cadence, hold period and staged release
        for (int v = 0; v < 15; v++) begin
            stepTo(vecs[v].cyc);
            checkOutput($sformatf("ce@%0d", vecs[v].cyc), 32'(ce), 32'(vecs[v].ce));
            checkOutput($sformatf("phase@%0d", vecs[v].cyc), 32'(phase), 32'(vecs[v].phase));
            checkOutput($sformatf("rst@%0d", vecs[v].cyc), 32'(rst_out_n), 32'(vecs[v].rst));
            checkOutput($sformatf("ready@%0d", vecs[v].cyc), 32'(ready), 32'(vecs[v].ready));
        end

        // D1=3 written while cnt1=2: current period finishes, then 3-cycle spacing
        stepTo(26);
        applyStimulus(1'b1, 3'd1, 8'd3, 1'b0);
        captureBits(13, c0, c1, p1);
        checkOutput("d1_to_3_ce1", c1, 32'h1248);

        // sw_rst in RUN: resets drop next edge, ch0 cadence continues, sequence repeats
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
        checkOutput("swrst_rst", 32'(rst_out_n), 32'd0);
        checkOutput("swrst_ready", 32'(ready), 32'd0);
        checkOutput("swrst_ce0", 32'(ce[0]), 32'd1);
        stepTo(42);
        checkOutput("swrst_ce0_next", 32'(ce[0]), 32'd0);
        stepTo(57);
        checkOutput("swrst_hold_end", 32'(rst_out_n), 32'd0);
        stepTo(58);
        checkOutput("swrst_rel0", 32'(rst_out_n), 32'b01);
        stepTo(61);
        checkOutput("swrst_gap", {30'd0, rst_out_n[1], ready}, 32'd0);
        stepTo(62);
        checkOutput("swrst_rel1", 32'(rst_out_n), 32'b11);
        checkOutput("swrst_ready_end", 32'(ready), 32'd1);

        // Disable channel 1, soft reset: ch1 released STAGE_GAP after ch0
        applyStimulus(1'b1, 3'd1, 8'd0, 1'b0);
        stepTo(65);
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
        seen = 1'b0;
        while (n_now < 83) begin
            stepTo(n_now + 1);
            seen |= ce[1];
        end
        checkOutput("dis_hold_rst", 32'(rst_out_n), 32'd0);
        stepTo(84);
        seen |= ce[1];
        checkOutput("dis_rel0", 32'(rst_out_n), 32'b01);
        while (n_now < 87) begin
            stepTo(n_now + 1);
            seen |= ce[1];
        end
        checkOutput("dis_gap", {30'd0, rst_out_n[1], ready}, 32'd0);
        stepTo(88);
        seen |= ce[1];
        checkOutput("dis_rel1", {30'd0, rst_out_n[1], ready}, 32'b11);
        checkOutput("dis_ce1_quiet", 32'(seen), 32'd0);

        // Re-enable D1=4: first pulse 4 cycles after the write
        applyStimulus(1'b1, 3'd1, 8'd4, 1'b0);
        captureBits(7, c0, c1, p1);
        checkOutput("reenable_ce1", c1, 32'h44);

        // Out-of-range channel write must not disturb either channel
        applyStimulus(1'b1, 3'd5, 8'd1, 1'b0);
        captureBits(8, c0, c1, p1);
        checkOutput("sel5_ce0", c0, 32'hAA);
        checkOutput("sel5_ce1", c1, 32'h44);

        // Soft reset, then async reset while ch1 still waits in STAGE
        applyStimulus(1'b0, 3'd0, 8'd0, 1'b1);
        stepTo(125);
        checkOutput("stage_rst", 32'(rst_out_n), 32'b01);
        checkOutput("stage_ready", 32'(ready), 32'd0);
        checkOutput("stage_phase", 32'(phase), 32'b01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_zero", {25'd0, ce, phase, rst_out_n, ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #5;
        n_now = 0;
        checkOutput("rerelease_zero", {25'd0, ce, phase, rst_out_n, ready}, 32'd0);
        captureBits(8, c0, c1, p1);
        checkOutput("default_ce0", c0, 32'h55);
        checkOutput("default_ce1", c1, 32'h40);
        checkOutput("default_phase1", p1, 32'h78);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/clk_reset_seq.md
Name: clk_reset_seq

Overview:
Generates the system's derived clock enables and sequenced resets from the single pixel clock (25.175 MHz). It replaces a fixed divide-by-2 CPU clock and a fixed reset pulse with NUM_CHAN programmable dividers, which can be changed at runtime glitch-free, plus a power-on and soft-reset sequencer. The sequencer releases each channel's reset in order, aligned to that channel's clock enable. It sits at the top level, feeding the CPU, video and peripheral blocks.

Parameters:
NUM_CHAN, 2, number of divider/reset channels (1..8)
DIV_W, 8, width of each divide-ratio register
DEFAULT_DIV, {8'd8, 8'd2}, packed reset-time divide ratios, channel 0 in the LSBs
HOLD_CYCLES, 16, clk cycles all resets are held after synchronised reset release
STAGE_GAP, 4, minimum clk cycles between successive channel releases

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft-reset request, pulse
div_we  in  1  divide-ratio write strobe
div_sel  in  3  channel index for the write
div_val  in  DIV_W  new divide ratio
ce  out  NUM_CHAN  per-channel one-cycle clock-enable pulse
phase  out  NUM_CHAN  per-channel ~50% square wave, for probing and export
rst_out_n  out  NUM_CHAN  per-channel active-low reset, sequenced release
ready  out  1  high once all channels are released

Behaviour:
- reset_n low, asynchronous: ce=0, phase=0, rst_out_n=0, ready=0, counters=0, div regs=DEFAULT_DIV, state=HOLD. Deassertion passes through a 2-flop synchroniser; internal logic starts on the 2nd clk edge after reset_n rises.
- Divider per channel, ratio D:
  - counter cnt runs 0..D-1; wraps to 0.
  - ce registered; high for exactly the cycle in which cnt==D-1.
  - phase = (cnt >= D>>1); D=1 gives ce=1 every cycle and phase=1.
  - D=0 disables the channel: cnt held at 0, ce=0, phase=0.
  - Dividers run from synchronised release, including during HOLD.
- Runtime writes:
  - div_we with div_sel<NUM_CHAN loads a shadow register. The shadow becomes active at the channel's next wrap.
  - If the active D is 0, the shadow becomes active on the next edge and cnt restarts at 0.
  - div_sel>=NUM_CHAN: the write is ignored.
  - A write coinciding with a wrap is used for the period starting at that wrap.
  - Of two writes to one channel before a wrap, the last one wins.
- Sequencer FSM, states HOLD, STAGE, RUN:
  - HOLD: counts HOLD_CYCLES, then goes to STAGE with idx=0.
  - STAGE: channel idx is released (rst_out_n[idx]=1) on the edge where its cnt wraps to 0, i.e. the cycle after its ce pulse. A disabled channel (D=0) is released immediately. The gap timer counts from each release; idx advances only after at least STAGE_GAP cycles and the target channel's next wrap. After the last channel is released, the FSM goes to RUN.
  - RUN: ready=1. Channels stay released.
- sw_rst, any state:
  - next edge: all rst_out_n=0, ready=0, state=HOLD, hold counter cleared.
  - Div regs and divider counters are retained.
  - A sw_rst held high keeps the FSM in HOLD.
- A reset_n assertion at any point overrides everything asynchronously.

Decomposition:
- Package clk_reset_pkg holds:
  - seq_state_t enum (HOLD, STAGE, RUN)
  - hold-counter width, computed as clog2 of HOLD_CYCLES+1
  - channel-index width
- Sub-module clk_div_chan holds one divider: D register, shadow register, counter, ce/phase logic, wrap output. It is instantiated NUM_CHAN times via generate. The sequencer stays in clk_reset_seq.

Test Plan:
- Power-on with defaults (D0=2, D1=8), reset_n rising at t=100ns:
  - ce[0] pulses every 2nd cycle; ce[1] every 8th cycle.
  - phase[1] is low 4 cycles, high 4 cycles.
  - rst_out_n all 0 for 16 cycles after sync release.
- Staged release:
  - rst_out_n[0] rises the cycle after a ce[0].
  - rst_out_n[1] rises at or after 4 cycles later, the cycle after a ce[1].
  - ready rises the same cycle as rst_out_n[1].
- Runtime write of D1=3 mid-period at cnt=2:
  - The current 8-cycle period completes unchanged.
  - Subsequent ce[1] spacing is 3 cycles; no short pulse appears.
- Disabled channel:
  - Write D1=0, then sw_rst.
  - ce[1] stays 0 and rst_out_n[1] releases STAGE_GAP cycles after rst_out_n[0], without deadlock.
  - Then write D1=4: ce[1] resumes, first pulse 4 cycles after the write.
- sw_rst during RUN:
  - Next edge: rst_out_n=00, ready=0.
  - ce[0] cadence is unbroken; the full HOLD/STAGE sequence repeats.
- Async reset mid-STAGE:
  - reset_n low between clk edges immediately forces all outputs to 0 and div regs to defaults.
  - Writes with div_sel=5 are ignored.
